// File: rtl/can_error_frame_ctrl_pkg.sv
// Shared types and default lengths for the CAN error frame controller.
// All bit counts are measured in sample points.
package can_err_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLAG,
      FLAG_WAIT,
      DELIM,
      INTERMISSION,
      SUSPEND,
      BUS_OFF
   } err_state_e;

   localparam int DEF_FLAG_LEN    = 6;
   localparam int DEF_DELIM_LEN   = 8;
   localparam int DEF_IFS_LEN     = 3;
   localparam int DEF_SUSPEND_LEN = 8;
   localparam int DEF_RECOV_BITS  = 11;
   localparam int DEF_RECOV_SEQS  = 128;

   // Dominant bits after the flag that make up one REC/TEC +8 event.
   localparam int DOM_LIMIT = 8;

   localparam logic CAN_DOMINANT  = 1'b0;
   localparam logic CAN_RECESSIVE = 1'b1;

endpackage

// File: rtl/can_error_frame_ctrl_if.sv
// Bit-level signals between the error frame controller, the error counter
// block and the TX mux. slave = controller side, master = surrounding logic.
interface can_error_frame_ctrl_if;

   logic sample_point;
   logic rx_bit;
   logic tx_active;
   logic error_detect;
   logic error_passive;
   logic bus_off;

   logic tx_override;
   logic tx_bit_o;
   logic err_frame_busy;
   logic frame_abort;
   logic dominant_after_flag;
   logic delim_form_error;
   logic suspend_active;
   logic clear_counters;
   can_err_pkg::err_state_e dbg_state;

   modport slave (
      input  sample_point, rx_bit, tx_active, error_detect, error_passive, bus_off,
      output tx_override, tx_bit_o, err_frame_busy, frame_abort, dominant_after_flag,
             delim_form_error, suspend_active, clear_counters, dbg_state
   );

   modport master (
      output sample_point, rx_bit, tx_active, error_detect, error_passive, bus_off,
      input  tx_override, tx_bit_o, err_frame_busy, frame_abort, dominant_after_flag,
             delim_form_error, suspend_active, clear_counters, dbg_state
   );

endinterface

// File: rtl/can_error_frame_ctrl_busoff_recovery.sv
// Counts runs of RECOV_BITS consecutive recessive bits while bus-off and
// pulses o_done on the bit that completes run number RECOV_SEQS.
module can_busoff_recovery #(
   parameter int RECOV_BITS = 11,
   parameter int RECOV_SEQS = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_bit,
   output logic o_done
);
   localparam int RUN_W = $clog2(RECOV_BITS) + 1;
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RECOV_BITS);
   localparam logic [7:0]       SEQ_LAST = 8'(RECOV_SEQS - 1);

   logic [RUN_W-1:0] r_run_cnt;
   logic [7:0]       r_seq_cnt;
   logic [RUN_W-1:0] w_run_inc;
   logic             w_run_end;

   assign w_run_inc = r_run_cnt + 1'b1;
   assign w_run_end = i_enable && i_bit && (w_run_inc == RUN_LAST);
   // Terminal check uses the count before increment, so seq_cnt never wraps.
   assign o_done    = w_run_end && (r_seq_cnt == SEQ_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cnt <= '0;
         r_seq_cnt <= '0;
      end else if (i_clear) begin
         r_run_cnt <= '0;
         r_seq_cnt <= '0;
      end else if (i_enable) begin
         if (!i_bit) begin
            r_run_cnt <= '0;
         end else if (w_run_end) begin
            r_run_cnt <= '0;
            r_seq_cnt <= o_done ? 8'd0 : r_seq_cnt + 8'd1;
         end else begin
            r_run_cnt <= w_run_inc;
         end
      end
   end

endmodule

// File: rtl/can_error_frame_ctrl.sv
// CAN error frame sequencer: flag, superposition wait, delimiter, intermission,
// suspend transmission and bus-off recovery; overrides the TX bit meanwhile.
module can_error_frame_ctrl
   import can_err_pkg::*;
#(
   parameter int FLAG_LEN    = DEF_FLAG_LEN,
   parameter int DELIM_LEN   = DEF_DELIM_LEN,
   parameter int IFS_LEN     = DEF_IFS_LEN,
   parameter int SUSPEND_LEN = DEF_SUSPEND_LEN,
   parameter int RECOV_BITS  = DEF_RECOV_BITS,
   parameter int RECOV_SEQS  = DEF_RECOV_SEQS
) (
   input  logic                 clk,
   input  logic                 rst,
   can_error_frame_ctrl_if.slave bus
);
   localparam int FLAG_W  = $clog2(FLAG_LEN) + 1;
   localparam int DOM_W   = $clog2(DOM_LIMIT) + 1;
   localparam int DELIM_W = $clog2(DELIM_LEN) + 1;
   localparam int IFS_W   = $clog2(IFS_LEN) + 1;
   localparam int SUSP_W  = $clog2(SUSPEND_LEN) + 1;

   localparam logic [FLAG_W-1:0]  FLAG_LAST  = FLAG_W'(FLAG_LEN);
   localparam logic [DOM_W-1:0]   DOM_LAST   = DOM_W'(DOM_LIMIT);
   localparam logic [DOM_W-1:0]   DOM_FIRST  = DOM_W'(1);
   localparam logic [DELIM_W-1:0] DELIM_LAST = DELIM_W'(DELIM_LEN);
   localparam logic [DELIM_W-1:0] DELIM_ONE  = DELIM_W'(1);
   localparam logic [IFS_W-1:0]   IFS_LAST   = IFS_W'(IFS_LEN);
   localparam logic [SUSP_W-1:0]  SUSP_LAST  = SUSP_W'(SUSPEND_LEN);

   err_state_e         r_state, w_state_nx;
   logic               r_was_tx, w_was_tx_nx;
   logic               r_passive, w_passive_nx;
   logic               r_last_rx, w_last_rx_nx;
   logic               r_dom_wrap, w_dom_wrap_nx;
   logic [FLAG_W-1:0]  r_flag_cnt, w_flag_nx, w_flag_inc;
   logic [FLAG_W-1:0]  r_eq_cnt, w_eq_nx;
   logic [DOM_W-1:0]   r_dom_cnt, w_dom_nx, w_dom_inc;
   logic [DELIM_W-1:0] r_delim_cnt, w_delim_nx, w_delim_inc;
   logic [IFS_W-1:0]   r_ifs_cnt, w_ifs_nx, w_ifs_inc;
   logic [SUSP_W-1:0]  r_susp_cnt, w_susp_nx, w_susp_inc;

   logic w_dominant, w_frame_abort, w_daf, w_dfe;
   logic w_rec_clear, w_rec_en, w_rec_done;

   assign w_dominant = (bus.rx_bit == CAN_DOMINANT);
   assign w_rec_en   = bus.sample_point && (r_state == BUS_OFF);

   can_busoff_recovery #(
      .RECOV_BITS (RECOV_BITS),
      .RECOV_SEQS (RECOV_SEQS)
   ) u_recov (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_rec_clear),
      .i_enable (w_rec_en),
      .i_bit    (bus.rx_bit),
      .o_done   (w_rec_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_was_tx    <= 1'b0;
         r_passive   <= 1'b0;
         r_last_rx   <= 1'b0;
         r_dom_wrap  <= 1'b0;
         r_flag_cnt  <= '0;
         r_eq_cnt    <= '0;
         r_dom_cnt   <= '0;
         r_delim_cnt <= '0;
         r_ifs_cnt   <= '0;
         r_susp_cnt  <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_was_tx    <= w_was_tx_nx;
         r_passive   <= w_passive_nx;
         r_last_rx   <= w_last_rx_nx;
         r_dom_wrap  <= w_dom_wrap_nx;
         r_flag_cnt  <= w_flag_nx;
         r_eq_cnt    <= w_eq_nx;
         r_dom_cnt   <= w_dom_nx;
         r_delim_cnt <= w_delim_nx;
         r_ifs_cnt   <= w_ifs_nx;
         r_susp_cnt  <= w_susp_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_was_tx_nx   = r_was_tx;
      w_passive_nx  = r_passive;
      w_last_rx_nx  = r_last_rx;
      w_dom_wrap_nx = r_dom_wrap;
      w_flag_nx     = r_flag_cnt;
      w_eq_nx       = r_eq_cnt;
      w_dom_nx      = r_dom_cnt;
      w_delim_nx    = r_delim_cnt;
      w_ifs_nx      = r_ifs_cnt;
      w_susp_nx     = r_susp_cnt;
      w_flag_inc    = r_flag_cnt + 1'b1;
      w_dom_inc     = r_dom_cnt + 1'b1;
      w_delim_inc   = r_delim_cnt + 1'b1;
      w_ifs_inc     = r_ifs_cnt + 1'b1;
      w_susp_inc    = r_susp_cnt + 1'b1;
      w_frame_abort = 1'b0;
      w_daf         = 1'b0;
      w_dfe         = 1'b0;
      w_rec_clear   = 1'b0;

      if (bus.sample_point) begin
         if (bus.bus_off && (r_state != BUS_OFF)) begin
            w_state_nx  = BUS_OFF;
            w_rec_clear = 1'b1;
         end else begin
            case (r_state)
               IDLE: if (bus.error_detect) begin
                  w_state_nx    = FLAG;
                  w_was_tx_nx   = bus.tx_active;
                  w_passive_nx  = bus.error_passive;
                  w_flag_nx     = '0;
                  w_eq_nx       = '0;
                  w_frame_abort = 1'b1;
               end
               FLAG: begin
                  // A passive flag only ends once the bus has been stable for FLAG_LEN bits.
                  if (r_passive) begin
                     w_last_rx_nx = bus.rx_bit;
                     if ((r_eq_cnt == '0) || (bus.rx_bit == r_last_rx)) w_eq_nx = r_eq_cnt + 1'b1;
                     else w_eq_nx = FLAG_W'(1);
                     if (w_eq_nx == FLAG_LAST) w_state_nx = FLAG_WAIT;
                  end else begin
                     w_flag_nx = w_flag_inc;
                     if (w_flag_inc == FLAG_LAST) w_state_nx = FLAG_WAIT;
                  end
                  w_dom_nx      = '0;
                  w_dom_wrap_nx = 1'b0;
               end
               FLAG_WAIT: begin
                  if (w_dominant) begin
                     if (w_dom_inc == DOM_LAST) begin
                        w_daf         = 1'b1;
                        w_dom_nx      = '0;
                        w_dom_wrap_nx = 1'b1;
                     end else begin
                        w_dom_nx = w_dom_inc;
                        w_daf    = (w_dom_inc == DOM_FIRST) && !r_dom_wrap && !r_was_tx;
                     end
                  end else begin
                     w_state_nx = DELIM;
                     w_delim_nx = DELIM_ONE;
                  end
               end
               DELIM: begin
                  if (w_dominant) begin
                     w_dfe         = 1'b1;
                     w_frame_abort = 1'b1;
                     w_state_nx    = FLAG;
                     w_passive_nx  = bus.error_passive;
                     w_flag_nx     = '0;
                     w_eq_nx       = '0;
                  end else if (w_delim_inc == DELIM_LAST) begin
                     w_state_nx = INTERMISSION;
                     w_ifs_nx   = '0;
                  end else begin
                     w_delim_nx = w_delim_inc;
                  end
               end
               INTERMISSION: begin
                  if (w_dominant || bus.error_detect) begin
                     w_state_nx = IDLE;
                  end else if (w_ifs_inc == IFS_LAST) begin
                     w_state_nx = (r_was_tx && bus.error_passive) ? SUSPEND : IDLE;
                     w_susp_nx  = '0;
                  end else begin
                     w_ifs_nx = w_ifs_inc;
                  end
               end
               SUSPEND: begin
                  if (w_dominant || bus.error_detect || (w_susp_inc == SUSP_LAST)) w_state_nx = IDLE;
                  else w_susp_nx = w_susp_inc;
               end
               BUS_OFF: if (w_rec_done) w_state_nx = IDLE;
               default: w_state_nx = IDLE;
            endcase
         end
      end
   end

   always_comb begin
      bus.tx_override         = 1'b0;
      bus.tx_bit_o            = 1'b0;
      bus.err_frame_busy      = (r_state != IDLE);
      bus.suspend_active      = (r_state == SUSPEND);
      bus.frame_abort         = w_frame_abort;
      bus.dominant_after_flag = w_daf;
      bus.delim_form_error    = w_dfe;
      bus.clear_counters      = w_rec_done;
      bus.dbg_state           = r_state;
      case (r_state)
         FLAG: begin
            bus.tx_override = 1'b1;
            bus.tx_bit_o    = r_passive ? CAN_RECESSIVE : CAN_DOMINANT;
         end
         FLAG_WAIT, DELIM, SUSPEND, BUS_OFF: begin
            bus.tx_override = 1'b1;
            bus.tx_bit_o    = CAN_RECESSIVE;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_can_error_frame_ctrl.sv
// Directed bench for can_error_frame_ctrl: each bit time is one sample_point
// strobe; pulses are read before the edge, state after it.
module tb_can_error_frame_ctrl;
   import can_err_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   can_error_frame_ctrl_if bus_if ();

   can_error_frame_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       p_fa, p_daf, p_dfe, p_clr;
   err_state_e post_st;
   int         acc_hi, acc_ovr, acc_fa, acc_susp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr_acc();
      acc_hi = 0; acc_ovr = 0; acc_fa = 0; acc_susp = 0;
   endtask

   task automatic do_bit(input logic rx, input logic err);
      @(negedge clk);
      bus_if.rx_bit       = rx;
      bus_if.error_detect = err;
      bus_if.sample_point = 1'b1;
      #2;
      p_fa  = bus_if.frame_abort;
      p_daf = bus_if.dominant_after_flag;
      p_dfe = bus_if.delim_form_error;
      p_clr = bus_if.clear_counters;
      if (bus_if.tx_override) acc_ovr++;
      if (bus_if.tx_override && bus_if.tx_bit_o) acc_hi++;
      if (bus_if.frame_abort) acc_fa++;
      if (bus_if.suspend_active) acc_susp++;
      @(negedge clk);
      bus_if.sample_point = 1'b0;
      bus_if.error_detect = 1'b0;
      post_st = bus_if.dbg_state;
   endtask

   task automatic run_bits(input int n, input logic rx);
      for (int i = 0; i < n; i++) do_bit(rx, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] daf_mask;
      int         rec;
      logic       got;
      n_checks = 0;
      n_errors = 0;
      clr_acc();
      rst = 1'b1;
      bus_if.sample_point  = 1'b0;
      bus_if.rx_bit        = CAN_RECESSIVE;
      bus_if.tx_active     = 1'b0;
      bus_if.error_detect  = 1'b0;
      bus_if.error_passive = 1'b0;
      bus_if.bus_off       = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state", 32'(bus_if.dbg_state), 32'(IDLE));
      chk("rst_tx_override", 32'(bus_if.tx_override), 0);
      chk("rst_tx_bit", 32'(bus_if.tx_bit_o), 0);
      chk("rst_busy", 32'(bus_if.err_frame_busy), 0);
      chk("rst_clear", 32'(bus_if.clear_counters), 0);
      rst = 1'b0;

      // Active flag as transmitter on a recessive bus
      bus_if.tx_active = 1'b1;
      clr_acc();
      do_bit(1'b1, 1'b1);
      chk("act_abort", 32'(p_fa), 1);
      chk("act_enter", 32'(post_st), 32'(FLAG));
      run_bits(6, 1'b1);
      chk("act_flag_ovr", 32'(acc_ovr), 6);
      chk("act_flag_hi", 32'(acc_hi), 0);
      chk("act_wait", 32'(post_st), 32'(FLAG_WAIT));
      run_bits(8, 1'b1);
      chk("act_ifs", 32'(post_st), 32'(INTERMISSION));
      run_bits(2, 1'b1);
      chk("act_ifs2", 32'(post_st), 32'(INTERMISSION));
      run_bits(1, 1'b1);
      chk("act_idle", 32'(post_st), 32'(IDLE));
      chk("act_abort_cnt", 32'(acc_fa), 1);

      // Receiver: dominant after flag
      bus_if.tx_active = 1'b0;
      do_bit(1'b0, 1'b1);
      run_bits(6, 1'b0);
      chk("rx_wait", 32'(post_st), 32'(FLAG_WAIT));
      daf_mask = '0;
      for (int i = 0; i < 9; i++) begin
         do_bit(1'b0, 1'b0);
         daf_mask[i] = p_daf;
      end
      chk("rx_daf_mask", 32'(daf_mask), 32'h081);
      chk("rx_still_wait", 32'(post_st), 32'(FLAG_WAIT));
      do_bit(1'b1, 1'b0);
      chk("rx_delim", 32'(post_st), 32'(DELIM));
      run_bits(10, 1'b1);
      chk("rx_idle", 32'(post_st), 32'(IDLE));

      // Passive transmitter with suspend
      bus_if.tx_active     = 1'b1;
      bus_if.error_passive = 1'b1;
      do_bit(1'b1, 1'b1);
      clr_acc();
      run_bits(6, 1'b1);
      chk("pas_flag_hi", 32'(acc_hi), 6);
      chk("pas_wait", 32'(post_st), 32'(FLAG_WAIT));
      run_bits(11, 1'b1);
      chk("pas_suspend", 32'(post_st), 32'(SUSPEND));
      clr_acc();
      run_bits(7, 1'b1);
      chk("pas_suspend7", 32'(post_st), 32'(SUSPEND));
      run_bits(1, 1'b1);
      chk("pas_idle", 32'(post_st), 32'(IDLE));
      chk("pas_susp_cnt", 32'(acc_susp), 8);
      chk("pas_susp_hi", 32'(acc_hi), 8);

      // Delimiter violation at delimiter bit 4
      bus_if.error_passive = 1'b0;
      do_bit(1'b1, 1'b1);
      run_bits(6, 1'b1);
      run_bits(3, 1'b1);
      chk("dv_delim", 32'(post_st), 32'(DELIM));
      do_bit(1'b0, 1'b0);
      chk("dv_form_err", 32'(p_dfe), 1);
      chk("dv_abort", 32'(p_fa), 1);
      chk("dv_reflag", 32'(post_st), 32'(FLAG));
      run_bits(17, 1'b1);
      chk("dv_idle", 32'(post_st), 32'(IDLE));

      // Bus-off entered from the delimiter, one dominant bit mid-run
      do_bit(1'b1, 1'b1);
      run_bits(7, 1'b1);
      chk("bo_delim", 32'(post_st), 32'(DELIM));
      bus_if.bus_off = 1'b1;
      do_bit(1'b1, 1'b0);
      chk("bo_enter", 32'(post_st), 32'(BUS_OFF));
      bus_if.bus_off = 1'b0;
      clr_acc();
      run_bits(5, 1'b1);
      do_bit(1'b0, 1'b0);
      chk("bo_hold", 32'(post_st), 32'(BUS_OFF));
      rec = 5;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         do_bit(1'b1, 1'b0);
         rec++;
         if (p_clr) got = 1'b1;
      end
      chk("bo_done_seen", 32'(got), 1);
      chk("bo_rec_count", 32'(rec), 1413);
      chk("bo_ovr", 32'(acc_ovr), 32'(rec + 1));
      chk("bo_idle", 32'(post_st), 32'(IDLE));

      // Asynchronous reset during flag bit 3
      do_bit(1'b1, 1'b1);
      run_bits(2, 1'b1);
      chk("rs_flag", 32'(post_st), 32'(FLAG));
      @(negedge clk);
      bus_if.rx_bit       = CAN_RECESSIVE;
      bus_if.sample_point = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("rs_ovr_drop", 32'(bus_if.tx_override), 0);
      chk("rs_state", 32'(bus_if.dbg_state), 32'(IDLE));
      @(negedge clk);
      bus_if.sample_point = 1'b0;
      rst = 1'b0;
      do_bit(1'b1, 1'b1);
      chk("rs_abort", 32'(p_fa), 1);
      clr_acc();
      run_bits(5, 1'b1);
      chk("rs_flag5", 32'(post_st), 32'(FLAG));
      run_bits(1, 1'b1);
      chk("rs_flag6", 32'(post_st), 32'(FLAG_WAIT));
      chk("rs_flag_ovr", 32'(acc_ovr), 6);
      chk("rs_flag_hi", 32'(acc_hi), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/can_error_frame_ctrl.md
Name: can_error_frame_ctrl

Overview:
- Sequences the CAN error frame once an error is detected: error flag (active or passive), flag superposition wait, error delimiter, intermission, suspend transmission, and bus-off recovery.
- Sits between the error detection/counter block and the bit-level transmit mux.
- Overrides the TX bit while an error frame is in progress.
- Feeds back the "dominant after flag" event and the bus-off counter-clear request.

Parameters:
- FLAG_LEN, 6, error flag length in bits.
- DELIM_LEN, 8, error delimiter length in recessive bits.
- IFS_LEN, 3, intermission length in bits.
- SUSPEND_LEN, 8, suspend-transmission length for an error-passive transmitter.
- RECOV_BITS, 11, consecutive recessive bits forming one bus-off recovery sequence.
- RECOV_SEQS, 128, recovery sequences required to leave bus-off.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sample_point  in  1  one-cycle strobe per bit time; all bit events are evaluated only here
- rx_bit  in  1  sampled bus level (0 = dominant)
- tx_active  in  1  node is transmitter of the current frame
- error_detect  in  1  OR of bit/stuff/form/ack/crc errors, valid with sample_point
- error_passive  in  1  node error state from the counter block
- bus_off  in  1  node error state from the counter block
- tx_override  out  1  high = this block drives the TX bit
- tx_bit_o  out  1  TX level while tx_override is high
- err_frame_busy  out  1  high in any state other than IDLE
- frame_abort  out  1  one-cycle pulse when a flag starts
- dominant_after_flag  out  1  one-cycle pulse: REC/TEC +8 event
- delim_form_error  out  1  one-cycle pulse: dominant bit sampled inside the delimiter
- suspend_active  out  1  high during SUSPEND
- clear_counters  out  1  one-cycle pulse at bus-off recovery completion

Behaviour:
- Reset values: state = IDLE; all counters 0; all outputs 0; was_tx = 0.
- Transitions occur only on cycles with sample_point = 1; the new state is visible from the next clk.
- Priority:
  - bus_off = 1 in any state other than BUS_OFF forces BUS_OFF and overrides everything else.
  - error_detect is ignored outside IDLE, SUSPEND and INTERMISSION.
- IDLE: on error_detect:
  - latch was_tx = tx_active;
  - pulse frame_abort;
  - go to FLAG with flag_cnt = 0 and eq_cnt = 0.
- FLAG:
  - tx_override = 1, tx_bit_o = error_passive ? 1 : 0 (error_passive is latched at entry).
  - Active flag: flag_cnt increments per bit; after FLAG_LEN bits go to FLAG_WAIT.
  - Passive flag: ends when FLAG_LEN consecutive equal rx_bit values have been sampled (eq_cnt resets on a level change).
- FLAG_WAIT:
  - tx_override = 1, tx_bit_o = 1.
  - Dominant sample: dom_cnt increments. Pulse dominant_after_flag when:
    - it is the first sample, dom_cnt == 1, and was_tx = 0; or
    - dom_cnt reaches 8; on this event dom_cnt is reloaded to 0.
  - Recessive sample: go to DELIM with delim_cnt = 1.
- DELIM:
  - tx_bit_o = 1.
  - Recessive sample: delim_cnt increments; at DELIM_LEN go to INTERMISSION.
  - Dominant sample: pulse delim_form_error and frame_abort, then re-enter FLAG.
- INTERMISSION:
  - tx_override = 0.
  - After IFS_LEN recessive bits: go to SUSPEND if was_tx && error_passive, else IDLE.
  - A dominant sample or error_detect goes to IDLE (SOF/overload is handled upstream).
- SUSPEND:
  - suspend_active = 1, tx_override = 1, tx_bit_o = 1.
  - After SUSPEND_LEN bits go to IDLE.
  - A dominant sample goes to IDLE (receiver role).
- BUS_OFF:
  - tx_override = 1, tx_bit_o = 1.
  - Recessive sample increments run_cnt; at RECOV_BITS: run_cnt = 0 and seq_cnt increments.
  - Dominant sample clears run_cnt only.
  - When seq_cnt reaches RECOV_SEQS: pulse clear_counters, clear seq_cnt, go to IDLE.
  - bus_off deasserting early is ignored.
- Counter widths: clog2 of the maximum count, plus 1. seq_cnt is 8 bits with no wrap; the terminal compare happens before increment.
- Asynchronous rst in any state returns to IDLE immediately; tx_override drops in the same cycle.

Decomposition:
- Package can_err_pkg:
  - state enum err_state_e {IDLE, FLAG, FLAG_WAIT, DELIM, INTERMISSION, SUSPEND, BUS_OFF};
  - default length constants;
  - CAN_DOMINANT / CAN_RECESSIVE constants.
- One sub-module, can_busoff_recovery: holds run_cnt and seq_cnt, with an enable, the sampled bit, and a done pulse.

Test Plan:
- Active flag: error_detect in IDLE with error_passive = 0, then recessive bus:
  - tx_bit_o = 0 for 6 bit times;
  - 8 delimiter bits, then 3 IFS bits;
  - back to IDLE after 17 bit times after the flag; frame_abort pulses once.
- Receiver dominant-after-flag: was_tx = 0, with 9 dominant samples after the flag:
  - dominant_after_flag pulses at dominant bit 1 and again at bit 8;
  - DELIM is entered on the first recessive sample.
- Passive transmitter: error_passive = 1, tx_active = 1, quiet bus:
  - tx_bit_o = 1 throughout; flag ends after 6 equal samples;
  - SUSPEND lasts 8 bits with suspend_active = 1, then IDLE.
- Delimiter violation: dominant at delimiter bit 4:
  - delim_form_error pulses, frame_abort pulses, state returns to FLAG.
- Bus-off recovery:
  - assert bus_off while in DELIM, then drive 128 × 11 recessive bits with one dominant inserted mid-run;
  - clear_counters pulses after exactly 1408 + the lost partial-run recessive samples;
  - state returns to IDLE.
- Reset mid-flag: rst asserted during flag bit 3:
  - tx_override = 0 in the same cycle; after release, error_detect starts a fresh 6-bit flag.
